// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Two-road intersection phase sequencer. The North-South (NS) group is the
// main road and rests in green. It yields to East-West (EW) only when an EW
// request has been latched. All-red clearance separates every change of
// right-of-way. The dwell counter advances only on the tick timebase enable.
//
// Optional feature: define TLC_PED_EN to add a pedestrian walk phase. This adds
// the ped_req/ped_walk ports and the PED_WALK state, which is inserted between
// ALLRED_A and EW_GREEN when a pedestrian request is pending.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   tick       in   timebase enable for the dwell counter
//   ew_req     in   EW vehicle demand, latched internally
//   ped_req    in   pedestrian button            (TLC_PED_EN only)
//   ped_walk   out  walk lamp                    (TLC_PED_EN only)
//   ns_red/ns_yellow/ns_green   out  NS lamp drives
//   ew_red/ew_yellow/ew_green   out  EW lamp drives
//   phase      out  current state encoding (3 bits)
// -----------------------------------------------------------------------------
module intersection_phase_scheduler #(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ew_req,
`ifdef TLC_PED_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ALLRED_INIT = 3'd0,
        NS_GREEN    = 3'd1,
        NS_YELLOW   = 3'd2,
        ALLRED_A    = 3'd3,
        EW_GREEN    = 3'd4,
        EW_YELLOW   = 3'd5,
        ALLRED_B    = 3'd6,
        PED_WALK    = 3'd7
    } state_e;

    // Counter load values: a state lasting DUR ticks is entered with DUR-1.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ew_pend_q;
    logic             ew_pend_d;
    logic             dwell_done_s;
    logic             yield_req_s;
    logic             enter_ew_s;

`ifdef TLC_PED_EN
    localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_TICKS - 1);

    logic ped_pend_q;
    logic ped_pend_d;
    logic enter_walk_s;

    assign yield_req_s  = ew_pend_q | ped_pend_q;
    assign enter_walk_s = (state_d == PED_WALK) && (state_q != PED_WALK);
`else
    // WALK_TICKS has no effect in this build; tie it off.
    logic [CNT_W-1:0] unused_walk_s;
    assign unused_walk_s = CNT_W'(WALK_TICKS - 1);

    assign yield_req_s = ew_pend_q;
`endif

    assign dwell_done_s = tick && (cnt_q == CNT_ZERO);
    assign enter_ew_s   = (state_d == EW_GREEN) && (state_q != EW_GREEN);

    // State, dwell counter and request latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ALLRED_INIT;
            cnt_q     <= ALLRED_LD;
            ew_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ew_pend_q <= ew_pend_d;
        end
    end

`ifdef TLC_PED_EN
    // Pedestrian request latch register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    // Pedestrian latch: clear on entry to PED_WALK wins over a new press.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (enter_walk_s) begin
            ped_pend_d = 1'b0;
        end else if (ped_req) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end
`endif

    // EW latch: clear on entry to EW_GREEN wins, so a request seen only in
    // that cycle is treated as already served.
    always_comb begin
        ew_pend_d = ew_pend_q;
        if (enter_ew_s) begin
            ew_pend_d = 1'b0;
        end else if (ew_req) begin
            ew_pend_d = 1'b1;
        end else begin
            ew_pend_d = ew_pend_q;
        end
    end

    // Next-state and dwell counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            ALLRED_INIT: begin
                if (dwell_done_s) begin
                    state_d = NS_GREEN;
                    cnt_d   = GREEN_LD;
                end else begin
                    state_d = ALLRED_INIT;
                end
            end
            NS_GREEN: begin
                // Minimum green served; counter parks at zero until a
                // pending request arrives together with a tick.
                if (dwell_done_s && yield_req_s) begin
                    state_d = NS_YELLOW;
                    cnt_d   = YELLOW_LD;
                end else begin
                    state_d = NS_GREEN;
                end
            end
            NS_YELLOW: begin
                if (dwell_done_s) begin
                    state_d = ALLRED_A;
                    cnt_d   = ALLRED_LD;
                end else begin
                    state_d = NS_YELLOW;
                end
            end
            ALLRED_A: begin
                if (dwell_done_s) begin
`ifdef TLC_PED_EN
                    if (ped_pend_q) begin
                        state_d = PED_WALK;
                        cnt_d   = WALK_LD;
                    end else begin
                        state_d = EW_GREEN;
                        cnt_d   = GREEN_LD;
                    end
`else
                    state_d = EW_GREEN;
                    cnt_d   = GREEN_LD;
`endif
                end else begin
                    state_d = ALLRED_A;
                end
            end
`ifdef TLC_PED_EN
            PED_WALK: begin
                if (dwell_done_s) begin
                    state_d = EW_GREEN;
                    cnt_d   = GREEN_LD;
                end else begin
                    state_d = PED_WALK;
                end
            end
`endif
            EW_GREEN: begin
                if (dwell_done_s) begin
                    state_d = EW_YELLOW;
                    cnt_d   = YELLOW_LD;
                end else begin
                    state_d = EW_GREEN;
                end
            end
            EW_YELLOW: begin
                if (dwell_done_s) begin
                    state_d = ALLRED_B;
                    cnt_d   = ALLRED_LD;
                end else begin
                    state_d = EW_YELLOW;
                end
            end
            ALLRED_B: begin
                if (dwell_done_s) begin
                    state_d = NS_GREEN;
                    cnt_d   = GREEN_LD;
                end else begin
                    state_d = ALLRED_B;
                end
            end
            default: begin
                // Illegal encoding: recover to a safe all-red start.
                state_d = ALLRED_INIT;
                cnt_d   = ALLRED_LD;
            end
        endcase
    end

    // Lamp decode from state only; anything unexpected shows all red.
    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        case (state_q)
            NS_GREEN: begin
                ns_green = 1'b1;
                ew_red   = 1'b1;
            end
            NS_YELLOW: begin
                ns_yellow = 1'b1;
                ew_red    = 1'b1;
            end
            EW_GREEN: begin
                ns_red   = 1'b1;
                ew_green = 1'b1;
            end
            EW_YELLOW: begin
                ns_red    = 1'b1;
                ew_yellow = 1'b1;
            end
            default: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
        endcase
    end

`ifdef TLC_PED_EN
    assign ped_walk = (state_q == PED_WALK);
`endif

    assign phase = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for intersection_phase_scheduler. A table of segments (optional
// reset, tick period, request levels, expected phase, length in clocks) is
// applied cycle by cycle; the lamps expected for each phase come from a small
// decode table derived from the lamp rules.
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       ew_req;
    logic       ped_req;
    logic       walk_s;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic [2:0] phase;

    int n_pass;
    int n_total;
    int cyc;

    typedef struct {
        bit          do_reset;
        int          period;
        bit          ew;
        bit          ped;
        logic [2:0]  ph;
        int          clocks;
        string       name;
    } row_t;

    row_t rows[$];

    intersection_phase_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .ew_req    (ew_req),
`ifdef TLC_PED_EN
        .ped_req   (ped_req),
        .ped_walk  (walk_s),
`endif
        .ns_red    (ns_red),
        .ns_yellow (ns_yellow),
        .ns_green  (ns_green),
        .ew_red    (ew_red),
        .ew_yellow (ew_yellow),
        .ew_green  (ew_green),
        .phase     (phase)
    );

`ifndef TLC_PED_EN
    assign walk_s = 1'b0;
`endif

    always #5 clk = ~clk;

    // Expected {phase, ns r/y/g, ew r/y/g, walk} for a given phase.
    function automatic logic [9:0] exp_vec(input logic [2:0] ph);
        logic [6:0] lamps;
        case (ph)
            3'd1:    lamps = 7'b001_100_0;
            3'd2:    lamps = 7'b010_100_0;
            3'd4:    lamps = 7'b100_001_0;
            3'd5:    lamps = 7'b100_010_0;
            3'd7:    lamps = 7'b100_100_1;
            default: lamps = 7'b100_100_0;
        endcase
        return {ph, lamps};
    endfunction

    function automatic logic [9:0] got_vec();
        return {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk_s};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d: got phase/lamps %b, expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic add(input bit r, input int per, input bit ew, input bit ped,
                       input logic [2:0] ph, input int n, input string name);
        row_t t;
        t.do_reset = r;
        t.period   = per;
        t.ew       = ew;
        t.ped      = ped;
        t.ph       = ph;
        t.clocks   = n;
        t.name     = name;
        rows.push_back(t);
    endtask

    task automatic run_row(input row_t t);
        if (t.do_reset) begin
            @(posedge clk);
            #1 reset = 1'b1;
            #1 check({t.name, "_reset"}, got_vec(), exp_vec(3'd0));
            @(posedge clk);
            #1 reset = 1'b0;
            cyc = 0;
        end
        for (int k = 0; k < t.clocks; k++) begin
            tick    = (((cyc + 1) % t.period) == 0);
            ew_req  = t.ew;
            ped_req = t.ped;
            @(posedge clk);
            #1;
            cyc++;
            check(t.name, got_vec(), exp_vec(t.ph));
        end
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b0;
        tick    = 1'b0;
        ew_req  = 1'b0;
        ped_req = 1'b0;
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;

        // No demand: two all-red ticks, then NS green rests.
        add(1'b1, 1, 1'b0, 1'b0, 3'd0, 1,   "idle_init");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 100, "idle_ns_hold");

        // EW pulse during NS green, then a request only in the EW-entry cycle.
        add(1'b1, 1, 1'b0, 1'b0, 3'd0, 1,  "pulse_init");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 4,  "pulse_nsg_a");
        add(1'b0, 1, 1'b1, 1'b0, 3'd1, 1,  "pulse_req");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 3,  "pulse_nsg_b");
        add(1'b0, 1, 1'b0, 1'b0, 3'd2, 3,  "pulse_nsy");
        add(1'b0, 1, 1'b0, 1'b0, 3'd3, 2,  "pulse_ara");
        add(1'b0, 1, 1'b1, 1'b0, 3'd4, 1,  "served_req");
        add(1'b0, 1, 1'b0, 1'b0, 3'd4, 7,  "pulse_ewg");
        add(1'b0, 1, 1'b0, 1'b0, 3'd5, 3,  "pulse_ewy");
        add(1'b0, 1, 1'b0, 1'b0, 3'd6, 2,  "pulse_arb");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 30, "no_second_ew");

        // Reset in the middle of EW green.
        add(1'b1, 1, 1'b0, 1'b0, 3'd0, 1,  "mid_init");
        add(1'b0, 1, 1'b1, 1'b0, 3'd1, 1,  "mid_req");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 7,  "mid_nsg");
        add(1'b0, 1, 1'b0, 1'b0, 3'd2, 3,  "mid_nsy");
        add(1'b0, 1, 1'b0, 1'b0, 3'd3, 2,  "mid_ara");
        add(1'b0, 1, 1'b0, 1'b0, 3'd4, 4,  "mid_ewg");
        add(1'b1, 1, 1'b0, 1'b0, 3'd0, 1,  "mid_rst");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 10, "mid_restart");

        // Tick one cycle in four with EW demand held: every dwell is 4x.
        add(1'b1, 4, 1'b1, 1'b0, 3'd0, 7,  "slow_init");
        add(1'b0, 4, 1'b1, 1'b0, 3'd1, 32, "slow_nsg");
        add(1'b0, 4, 1'b1, 1'b0, 3'd2, 12, "slow_nsy");
        add(1'b0, 4, 1'b1, 1'b0, 3'd3, 8,  "slow_ara");
        add(1'b0, 4, 1'b1, 1'b0, 3'd4, 32, "slow_ewg");
        add(1'b0, 4, 1'b1, 1'b0, 3'd5, 12, "slow_ewy");
        add(1'b0, 4, 1'b1, 1'b0, 3'd6, 8,  "slow_arb");
        add(1'b0, 4, 1'b1, 1'b0, 3'd1, 32, "slow_nsg2");
        add(1'b0, 4, 1'b1, 1'b0, 3'd2, 4,  "slow_nsy2");

`ifdef TLC_PED_EN
        // Pedestrian press during NS green inserts a walk phase.
        add(1'b1, 1, 1'b0, 1'b0, 3'd0, 1,  "ped_init");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 3,  "ped_nsg_a");
        add(1'b0, 1, 1'b0, 1'b1, 3'd1, 1,  "ped_press");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 4,  "ped_nsg_b");
        add(1'b0, 1, 1'b0, 1'b0, 3'd2, 3,  "ped_nsy");
        add(1'b0, 1, 1'b0, 1'b0, 3'd3, 2,  "ped_ara");
        add(1'b0, 1, 1'b0, 1'b0, 3'd7, 4,  "ped_walk");
        add(1'b0, 1, 1'b0, 1'b0, 3'd4, 8,  "ped_ewg");
        add(1'b0, 1, 1'b0, 1'b0, 3'd5, 3,  "ped_ewy");
        add(1'b0, 1, 1'b0, 1'b0, 3'd6, 2,  "ped_arb");
        add(1'b0, 1, 1'b0, 1'b0, 3'd1, 10, "ped_ns_hold");
`endif

        foreach (rows[i]) begin
            run_row(rows[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
